dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data-memory port between the riscv_core load/store path and an
//  external burst requester (DMA/debug loader). Round-robin arbitration on ties; core
//  accesses are single-cycle, external accesses are bursts of consecutive words.
//  Sits between the core/external masters and dmem; the core stalls while it loses.
// PARAMETERS
//  LEN_W       4   width of ext_len; burst = ext_len+1 beats (1..2^LEN_W)
//  WORD_BYTES  4   address stride per burst beat, in bytes
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  reset        in   1       synchronous, active-low reset
//  core_req     in   1       core requests a dmem access this cycle
//  core_we      in   1       core access is a write
//  core_addr    in   32      core byte address
//  core_wdata   in   32      core write data
//  core_rdata   out  32      read data to core (= mem_rdata)
//  core_stall   out  1       core access not performed this cycle; core must hold
//  ext_req      in   1       external burst request (sampled only in IDLE)
//  ext_we       in   1       burst is a write burst
//  ext_addr     in   32      burst base byte address
//  ext_len      in   LEN_W   beats minus one
//  ext_wdata    in   32      write data for current beat
//  ext_rdata    out  32      read data for current beat (= mem_rdata)
//  ext_beat     out  1       a burst beat is performed this cycle
//  ext_done     out  1       current beat is the last of the burst
//  mem_we       out  1       dmem write enable
//  mem_addr     out  32      dmem address
//  mem_wdata    out  32      dmem write data
//  mem_rdata    in   32      dmem read data (combinational read)
//  stall_cycles out  32      core stall counter (see CONFIGURATION)
// BEHAVIOUR
//  - States IDLE, EXT. Registers: state, rr_last (CORE/EXT), base, len, we_l, cnt[LEN_W-1:0].
//  - Reset (reset==0 at edge): state=IDLE, rr_last=EXT, cnt=0. While reset==0 mem_we=0.
//  - IDLE winner: core_req only -> CORE; ext_req only -> EXT; both -> opposite of rr_last.
//  - IDLE, CORE wins: mem_* driven from core_* combinationally, core_stall=0, read data same
//    cycle, write commits at edge; rr_last<=CORE; stay IDLE.
//  - IDLE, EXT wins: no memory access (mem_we=0); latch base<=ext_addr, len<=ext_len,
//    we_l<=ext_we, cnt<=0; rr_last<=EXT; next state EXT. core_stall=core_req.
//  - EXT: one beat per cycle; ext_beat=1, mem_addr=base+cnt*WORD_BYTES (mod 2^32),
//    mem_we=we_l, mem_wdata=ext_wdata; cnt++. core_stall=core_req throughout.
//  - Last beat (cnt==len): ext_done=1, next state IDLE. Burst latency = 1 + (len+1) cycles.
//  - ext_req/ext_* inputs other than ext_wdata are ignored in EXT; dropping ext_req mid-burst
//    does not abort. ext_req still high in IDLE after done -> new arbitration (core wins tie).
//  - No request in IDLE: mem_we=0, mem_addr=core_addr, all status outputs 0.
//  - Reset mid-burst: burst aborted, no further beats, ext_done never asserted for it.
//  - core_stall=0 whenever core_req=0. ext_beat/ext_done=0 outside EXT.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: stall_cycles counts cycles with core_stall=1, saturates at
//    2^32-1, cleared by reset. Not defined: stall_cycles tied to 0, no counter logic.
// TESTING
//  - core_req=1,we=1,addr=0x40,wdata=0xDEADBEEF, no ext -> core_stall=0, mem_we=1 same cycle.
//  - ext_req, addr=0x100,len=3,we=1 -> 1 idle cycle, beats at 0x100,0x104,0x108,0x10C, done on 4th.
//  - core_req & ext_req after reset -> core first (stall=0); next tie -> ext wins, core_stall=1 5 cycles for len=3.
//  - ext burst base=0xFFFFFFF8,len=3 -> addrs 0xFFFFFFF8,0xFFFFFFFC,0x0,0x4.
//  - reset=0 on 2nd beat of len=7 write burst -> mem_we=0 thereafter, state IDLE, no ext_done.
//  - STATS_EN: 5-cycle core stall -> stall_cycles=5; without macro stays 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the core load/store
// path (single-cycle accesses) and an external burst master (DMA/debug loader).
// Round-robin arbitration on simultaneous requests; the core stalls while it loses.
// Optional feature macro: DMEM_ARB_STATS_EN enables the saturating core stall counter
// on stall_cycles; without it stall_cycles is tied to zero.
module dmem_arbiter #(
  parameter int LEN_W      = 4,
  parameter int WORD_BYTES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [31:0]      core_addr,
  input  logic [31:0]      core_wdata,
  output logic [31:0]      core_rdata,
  output logic             core_stall,
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic [31:0]      ext_addr,
  input  logic [LEN_W-1:0] ext_len,
  input  logic [31:0]      ext_wdata,
  output logic [31:0]      ext_rdata,
  output logic             ext_beat,
  output logic             ext_done,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      stall_cycles
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXT  = 1'b1
  } state_t;

  // Encoding of which master won the most recent arbitration.
  localparam logic RR_CORE = 1'b0;
  localparam logic RR_EXT  = 1'b1;

  state_t           state_q;
  logic             rr_last_q;
  logic [31:0]      base_q;
  logic [LEN_W-1:0] len_q;
  logic             we_l_q;
  logic [LEN_W-1:0] cnt_q;

  logic             core_win_s;
  logic             ext_win_s;
  logic             last_beat_s;
  logic [31:0]      beat_addr_s;

  // Both masters read the same combinational memory data.
  assign core_rdata = mem_rdata;
  assign ext_rdata  = mem_rdata;

  // Arbitration in IDLE: a lone requester wins; on a tie the master that did not win last time goes.
  always_comb begin
    core_win_s = 1'b0;
    ext_win_s  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (core_req && ext_req) begin
        core_win_s = (rr_last_q == RR_EXT);
        ext_win_s  = (rr_last_q == RR_CORE);
      end else begin
        core_win_s = core_req;
        ext_win_s  = ext_req;
      end
    end else begin
      core_win_s = 1'b0;
      ext_win_s  = 1'b0;
    end
  end

  // Beat address wraps modulo 2^32; last beat when the counter reaches the latched length.
  assign beat_addr_s = base_q + (32'(cnt_q) * 32'(WORD_BYTES));
  assign last_beat_s = (cnt_q == len_q);

  // Memory port mux and master status; reset forces writes and burst status off.
  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    core_stall = 1'b0;
    ext_beat   = 1'b0;
    ext_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        mem_we     = core_win_s & core_we & reset;
        core_stall = core_req & ~core_win_s;
      end
      ST_EXT: begin
        mem_addr   = beat_addr_s;
        mem_wdata  = ext_wdata;
        mem_we     = we_l_q & reset;
        core_stall = core_req;
        ext_beat   = reset;
        ext_done   = reset & last_beat_s;
      end
      default: begin
        mem_we     = 1'b0;
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        core_stall = 1'b0;
        ext_beat   = 1'b0;
        ext_done   = 1'b0;
      end
    endcase
  end

  // Arbiter FSM: latch burst parameters on an external win, then step one beat per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rr_last_q <= RR_EXT;
      base_q    <= 32'h0000_0000;
      len_q     <= '0;
      we_l_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ext_win_s) begin
            base_q    <= ext_addr;
            len_q     <= ext_len;
            we_l_q    <= ext_we;
            cnt_q     <= '0;
            rr_last_q <= RR_EXT;
            state_q   <= ST_EXT;
          end else if (core_win_s) begin
            rr_last_q <= RR_CORE;
            state_q   <= ST_IDLE;
          end else begin
            state_q   <= ST_IDLE;
          end
        end
        ST_EXT: begin
          cnt_q <= cnt_q + 1'b1;
          if (last_beat_s) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_EXT;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Next stall count: increment on a stalled core cycle, holding at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (core_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: expected per-cycle port behaviour is queued as each
// step is driven and compared mid-cycle. Memory read data is modelled as addr ^ RD_KEY.
module tb_dmem_arbiter;

  localparam int          LEN_W  = 4;
  localparam logic [31:0] RD_KEY = 32'hA5A5_0F0F;

  logic             clk;
  logic             reset;
  logic             core_req, core_we;
  logic [31:0]      core_addr, core_wdata, core_rdata;
  logic             core_stall;
  logic             ext_req, ext_we;
  logic [31:0]      ext_addr;
  logic [LEN_W-1:0] ext_len;
  logic [31:0]      ext_wdata, ext_rdata;
  logic             ext_beat, ext_done;
  logic             mem_we;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  logic [31:0]      stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;
  int model_stalls = 0;

  typedef struct {
    string       tag;
    logic        we;
    logic        addr_v;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        beat;
    logic        done;
  } exp_t;

  exp_t sb_q[$];

  dmem_arbiter #(.LEN_W(LEN_W), .WORD_BYTES(4)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_len(ext_len),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_beat(ext_beat), .ext_done(ext_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_cycles(stall_cycles)
  );

  // Combinational memory model.
  assign mem_rdata = mem_addr ^ RD_KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic we, input logic addr_v,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic stall, input logic beat, input logic done);
    exp_t e;
    e.tag = tag; e.we = we; e.addr_v = addr_v; e.addr = addr; e.wdata = wd;
    e.stall = stall; e.beat = beat; e.done = done;
    return e;
  endfunction

  // One non-reset cycle: queue expectation, compare mid-cycle, advance to just after the edge.
  task automatic run_cycle(input exp_t e);
    exp_t x;
    logic [31:0] exp_stat;
    sb_q.push_back(e);
    @(negedge clk);
    x = sb_q.pop_front();
`ifdef DMEM_ARB_STATS_EN
    exp_stat = 32'(model_stalls);
`else
    exp_stat = 32'h0;
`endif
    chk({x.tag, "_we"}, {31'b0, mem_we}, {31'b0, x.we});
    if (x.addr_v) begin
      chk({x.tag, "_addr"}, mem_addr, x.addr);
      chk({x.tag, "_crdata"}, core_rdata, x.addr ^ RD_KEY);
      chk({x.tag, "_erdata"}, ext_rdata, x.addr ^ RD_KEY);
    end
    if (x.we) chk({x.tag, "_wdata"}, mem_wdata, x.wdata);
    chk({x.tag, "_stall"}, {31'b0, core_stall}, {31'b0, x.stall});
    chk({x.tag, "_beat"}, {31'b0, ext_beat}, {31'b0, x.beat});
    chk({x.tag, "_done"}, {31'b0, ext_done}, {31'b0, x.done});
    chk({x.tag, "_stat"}, stall_cycles, exp_stat);
    if (x.stall) model_stalls++;
    @(posedge clk);
    #1;
  endtask

  // One cycle with reset low: no writes, no completion.
  task automatic reset_cycle(input string tag);
    @(negedge clk);
    chk({tag, "_we"}, {31'b0, mem_we}, 32'h0);
    chk({tag, "_done"}, {31'b0, ext_done}, 32'h0);
    @(posedge clk);
    #1;
    model_stalls = 0;
  endtask

  initial begin
    reset = 1'b0;
    core_req = 1'b0; core_we = 1'b1; core_addr = 32'h0000_0010; core_wdata = 32'h1111_1111;
    ext_req = 1'b0; ext_we = 1'b1; ext_addr = 32'h0; ext_len = 4'd0; ext_wdata = 32'h0;
    @(posedge clk);
    #1;
    reset_cycle("rst0");
    reset_cycle("rst1");
    reset = 1'b1;

    // Single-cycle core write, then core read.
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h0000_0040; core_wdata = 32'hDEAD_BEEF;
    run_cycle(mk("cwr", 1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0));
    core_we = 1'b0; core_addr = 32'h0000_0080;
    run_cycle(mk("crd", 1'b0, 1'b1, 32'h0000_0080, 32'h0, 1'b0, 1'b0, 1'b0));

    // External write burst of 4 beats; inputs other than wdata change after the grant.
    core_req = 1'b0;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h0000_0100; ext_len = 4'd3;
    run_cycle(mk("b1win", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 32'hBAD0_0000; ext_len = 4'd0;
    for (int i = 0; i < 4; i++) begin
      ext_wdata = 32'h0000_1000 + 32'(i);
      run_cycle(mk($sformatf("b1beat%0d", i), 1'b1, 1'b1, 32'h0000_0100 + 32'(4 * i),
                   32'h0000_1000 + 32'(i), 1'b0, 1'b1, (i == 3)));
    end

    // No request: address follows core_addr, nothing asserted.
    core_addr = 32'h0000_0055;
    run_cycle(mk("idle", 1'b0, 1'b1, 32'h0000_0055, 32'h0, 1'b0, 1'b0, 1'b0));

    // Ties: last winner was external, so core goes first, then the burst with core stalled.
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0200;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h0000_0300; ext_len = 4'd3;
    run_cycle(mk("tie1", 1'b0, 1'b1, 32'h0000_0200, 32'h0, 1'b0, 1'b0, 1'b0));
    run_cycle(mk("tie2win", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      run_cycle(mk($sformatf("b2beat%0d", i), 1'b0, 1'b1, 32'h0000_0300 + 32'(4 * i),
                   32'h0, 1'b1, 1'b1, (i == 3)));
    end
    run_cycle(mk("tie3", 1'b0, 1'b1, 32'h0000_0200, 32'h0, 1'b0, 1'b0, 1'b0));
    core_req = 1'b0; ext_req = 1'b0;
    run_cycle(mk("idle2", 1'b0, 1'b1, 32'h0000_0200, 32'h0, 1'b0, 1'b0, 1'b0));

    // Burst crossing the top of the address space.
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'hFFFF_FFF8; ext_len = 4'd3;
    run_cycle(mk("b3win", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    ext_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ext_wdata = 32'h0000_2000 + 32'(i);
      run_cycle(mk($sformatf("b3beat%0d", i), 1'b1, 1'b1, 32'hFFFF_FFF8 + 32'(4 * i),
                   32'h0000_2000 + 32'(i), 1'b0, 1'b1, (i == 3)));
    end

    // Reset on the second beat of an 8-beat write burst aborts it.
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h0000_0400; ext_len = 4'd7;
    run_cycle(mk("b4win", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    ext_req = 1'b0; ext_wdata = 32'h0000_3000;
    run_cycle(mk("b4beat0", 1'b1, 1'b1, 32'h0000_0400, 32'h0000_3000, 1'b0, 1'b1, 1'b0));
    reset = 1'b0;
    reset_cycle("b4rst0");
    reset_cycle("b4rst1");
    reset = 1'b1;
    core_addr = 32'h0000_0600;
    for (int i = 0; i < 10; i++) begin
      run_cycle(mk($sformatf("post%0d", i), 1'b0, 1'b1, 32'h0000_0600, 32'h0,
                   1'b0, 1'b0, 1'b0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
